// File: rtl/register_writeback_if.sv
// Register write-side bundle: sequencer controls and commit inputs in, phase strobes,
// architectural registers and stack write port out.
interface register_writeback_if;
    logic        run;
    logic [3:0]  wsel_1;
    logic [3:0]  wsel_2;
    logic [3:0]  wsel_3;
    logic [31:0] write_data;
    logic [3:0]  eip_inc;
    logic        clock_3;
    logic        clock_5;
    logic        clock_7;
    logic [2:0]  phase;
    logic        busy;
    logic [31:0] eip;
    logic [31:0] ebp;
    logic [31:0] esp;
    logic [31:0] eax;
    logic [31:0] edi;
    logic [31:0] ebx;
    logic        stack_we;
    logic [31:0] stack_waddr;
    logic [31:0] stack_wdata;
    logic        sel_err;

    modport slave (
        input  run, wsel_1, wsel_2, wsel_3, write_data, eip_inc,
        output clock_3, clock_5, clock_7, phase, busy,
        output eip, ebp, esp, eax, edi, ebx,
        output stack_we, stack_waddr, stack_wdata, sel_err
    );

    modport master (
        output run, wsel_1, wsel_2, wsel_3, write_data, eip_inc,
        input  clock_3, clock_5, clock_7, phase, busy,
        input  eip, ebp, esp, eax, edi, ebx,
        input  stack_we, stack_waddr, stack_wdata, sel_err
    );
endinterface

// File: rtl/register_writeback.sv
// 8-phase sequencer plus register file write side; commits land on the edges ending phases 3/5/7.
// No backpressure: run is only sampled in IDLE and at phase 7, so an instruction always completes.
module register_writeback #(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000,
    parameter logic [31:0] STACK_TOP = 32'h0000_0100,
    parameter logic [31:0] ESP_STEP  = 32'd4
) (
    input  logic                  clock,
    input  logic                  reset,
    register_writeback_if.slave   bus
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [31:0] eip_q, ebp_q, esp_q, eax_q, edi_q, ebx_q;
    logic [31:0] eip_d, ebp_d, esp_d, eax_d, edi_d, ebx_d;
    logic        swe_q, swe_d;
    logic [31:0] swa_q, swa_d, swd_q, swd_d;
    logic        err_q, err_d;
    logic        jump_q, jump_d;
    logic        commit_en;
    logic [3:0]  code;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                phase_d = 3'd0;
                if (bus.run) begin
                    state_d = EXEC;
                    phase_d = 3'd1;
                end
            end
            EXEC: begin
                if (phase_q == 3'd7) begin
                    phase_d = 3'd0;
                    if (!bus.run) state_d = IDLE;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = 3'd0;
            end
        endcase
    end

    assign commit_en = (state_q == EXEC) &&
                       ((phase_q == 3'd3) || (phase_q == 3'd5) || (phase_q == 3'd7));

    always_comb begin
        code = 4'd0;
        case (phase_q)
            3'd3:    code = bus.wsel_1;
            3'd5:    code = bus.wsel_2;
            3'd7:    code = bus.wsel_3;
            default: code = 4'd0;
        endcase
    end

    always_comb begin
        eip_d  = eip_q;
        ebp_d  = ebp_q;
        esp_d  = esp_q;
        eax_d  = eax_q;
        edi_d  = edi_q;
        ebx_d  = ebx_q;
        swe_d  = 1'b0;
        swa_d  = swa_q;
        swd_d  = swd_q;
        err_d  = err_q;
        jump_d = jump_q;
        if ((state_q != EXEC) || (phase_q == 3'd0)) jump_d = 1'b0;
        if (commit_en) begin
            case (code)
                4'd0: ;
                4'd1: begin
                    eip_d  = bus.write_data;
                    jump_d = 1'b1;
                end
                4'd2: ebp_d = bus.write_data;
                4'd3: esp_d = bus.write_data;
                4'd4: eax_d = bus.write_data;
                4'd5: edi_d = bus.write_data;
                4'd6: ebx_d = bus.write_data;
                4'd7: esp_d = esp_q + ESP_STEP;
                4'd8: esp_d = esp_q - ESP_STEP;
                4'd9: begin
                    swe_d = 1'b1;
                    swa_d = esp_q;
                    swd_d = bus.write_data;
                end
                default: err_d = 1'b1;
            endcase
            // End of instruction: an explicit eip write or an earlier jump suppresses the advance.
            if (phase_q == 3'd7) begin
                if ((code != 4'd1) && !jump_q) eip_d = eip_q + {28'd0, bus.eip_inc};
                jump_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eip_q  <= RESET_EIP;
            ebp_q  <= STACK_TOP;
            esp_q  <= STACK_TOP;
            eax_q  <= 32'd0;
            edi_q  <= 32'd0;
            ebx_q  <= 32'd0;
            swe_q  <= 1'b0;
            swa_q  <= 32'd0;
            swd_q  <= 32'd0;
            err_q  <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            eip_q  <= eip_d;
            ebp_q  <= ebp_d;
            esp_q  <= esp_d;
            eax_q  <= eax_d;
            edi_q  <= edi_d;
            ebx_q  <= ebx_d;
            swe_q  <= swe_d;
            swa_q  <= swa_d;
            swd_q  <= swd_d;
            err_q  <= err_d;
            jump_q <= jump_d;
        end
    end

    assign bus.busy        = (state_q == EXEC);
    assign bus.phase       = phase_q;
    assign bus.clock_3     = (state_q == EXEC) && (phase_q == 3'd3);
    assign bus.clock_5     = (state_q == EXEC) && (phase_q == 3'd5);
    assign bus.clock_7     = (state_q == EXEC) && (phase_q == 3'd7);
    assign bus.eip         = eip_q;
    assign bus.ebp         = ebp_q;
    assign bus.esp         = esp_q;
    assign bus.eax         = eax_q;
    assign bus.edi         = edi_q;
    assign bus.ebx         = ebx_q;
    assign bus.stack_we    = swe_q;
    assign bus.stack_waddr = swa_q;
    assign bus.stack_wdata = swd_q;
    assign bus.sel_err     = err_q;

endmodule
